// File: rtl/pls_gen_pkg.sv
// pls_gen_pkg: FSM encodings and limits shared by pulse generator and pulse counter blocks
package pls_gen_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    STEP  = 2'd3
  } pls_state_t;
  localparam int MIN_DIV = 4;
endpackage

// File: rtl/pls_gen_sync_edge.sv
// sync_edge: two-stage synchronizer with rising-edge detect
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic lvl,
  output logic rise
);
  logic s0, s1;
  // s0 captures the raw input, s1 is the settled level
  always_ff @(posedge clk or negedge rst)
    if (!rst) {s1, s0} <= 2'b00;
    else {s1, s0} <= {s0, d};
  assign lvl = s1;
  assign rise = s0 & ~s1;
endmodule

// File: rtl/pls_gen.sv
// pls_gen: 50% duty square-wave generator with run/step/clear control and fall-edge tick
module pls_gen import pls_gen_pkg::*; #(
  parameter int DIV = 500000
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       clr,
  input  logic       run,
  input  logic       step,
  output logic       plso,
  output logic       tick,
  output logic [1:0] state
);
  localparam int W = $clog2(DIV < MIN_DIV ? MIN_DIV : DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);
  localparam logic [W-1:0] HALF = W'(DIV / 2);
  logic clr_e, run_s1, step_e, clr_unused, step_unused;
  logic wrap, en;
  logic [W-1:0] cnt, cnt_n;
  pls_state_t st, st_n;
  sync_edge u_clr  (.clk(clk), .rst(rst), .d(clr),  .lvl(clr_unused),  .rise(clr_e));
  sync_edge u_run  (.clk(clk), .rst(rst), .d(run),  .lvl(run_s1),      .rise());
  sync_edge u_step (.clk(clk), .rst(rst), .d(step), .lvl(step_unused), .rise(step_e));
  assign wrap = cnt == LAST;
  assign cnt_n = wrap ? '0 : cnt + 1'b1;
  // DRAIN and STEP still count through their final wrap cycle
  assign en = (st_n != IDLE) | (wrap & st[1]);
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) st <= IDLE;
    else st <= st_n;
  // next state: clear wins, then a high run level always means RUN
  always_comb
    st_n = clr_e ? (run_s1 ? RUN : IDLE) :
           run_s1 ? RUN :
           (st == IDLE) ? (step_e ? STEP : IDLE) :
           (st == RUN) ? (plso ? DRAIN : IDLE) :
           (wrap ? IDLE : st);
  // period counter, square wave and tick; clear restarts the period silently
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= '0;
      plso <= 1'b0;
      tick <= 1'b0;
    end else if (clr_e) begin
      cnt <= '0;
      plso <= 1'b0;
      tick <= 1'b0;
    end else begin
      tick <= en & wrap;
      if (en) begin
        cnt <= cnt_n;
        plso <= cnt_n >= HALF;
      end
    end
  // debug state output
  always_comb state = st;
endmodule

// File: tb/tb_pls_gen.sv
// tb_pls_gen: randomized and directed checks of pls_gen against a behavioural model
module tb_pls_gen;
  localparam int P = 8;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_STEP = 3;
  logic clk = 0, rst = 0, clr = 0, run = 0, step = 0;
  logic plso, tick;
  logic [1:0] state;
  int checks = 0, errors = 0;
  int mcnt = 0, mmode = M_IDLE, mtick = 0;
  bit rq1, rq2, sq1, sq2, cq1, cq2;

  pls_gen #(.DIV(P)) dut (
    .rst(rst), .clk(clk), .clr(clr), .run(run), .step(step),
    .plso(plso), .tick(tick), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // behavioural reference: inputs seen two edges late, period of P counts
  task automatic model();
    bit r, se, ce;
    int nm;
    if (!rst) begin
      mcnt = 0; mmode = M_IDLE; mtick = 0;
      {rq1, rq2, sq1, sq2, cq1, cq2} = '0;
      return;
    end
    r = rq2; se = sq1 & ~sq2; ce = cq1 & ~cq2;
    mtick = 0;
    if (ce) begin
      mcnt = 0;
      mmode = r ? M_RUN : M_IDLE;
    end else begin
      if (r) nm = M_RUN;
      else if (mmode == M_IDLE) nm = se ? M_STEP : M_IDLE;
      else if (mmode == M_RUN) nm = (mcnt >= P / 2) ? M_DRAIN : M_IDLE;
      else nm = (mcnt == P - 1) ? M_IDLE : mmode;
      if (nm != M_IDLE || mmode == M_DRAIN || mmode == M_STEP) begin
        mtick = (mcnt == P - 1) ? 1 : 0;
        mcnt = (mcnt + 1) % P;
      end
      mmode = nm;
    end
    rq2 = rq1; rq1 = run;
    sq2 = sq1; sq1 = step;
    cq2 = cq1; cq1 = clr;
  endtask

  task automatic cyc();
    @(posedge clk);
    model();
    @(negedge clk);
    chk("cnt", int'(dut.cnt), mcnt);
    chk("plso", int'(plso), (mcnt >= P / 2) ? 1 : 0);
    chk("tick", int'(tick), mtick);
    chk("state", int'(state), mmode);
  endtask

  task automatic run_until(input int c);
    int n = 0;
    while (mcnt != c && n < 40) begin
      cyc();
      n++;
    end
    chk("reach_cnt", int'(dut.cnt), c);
  endtask

  initial begin
    int last, first, ticks, highs, n;
    run = 1;
    repeat (3) cyc();
    rst = 1;
    last = -1; first = -1;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (plso && first < 0) first = i;
      if (tick) begin
        if (last >= 0) chk("tick_period", i - last, P);
        last = i;
      end
    end
    chk("first_rise", first, 6);

    run_until(7);
    run_until(0);
    run = 0;
    repeat (5) cyc();
    chk("hold_cnt", int'(dut.cnt), 2);
    chk("hold_state", int'(state), M_IDLE);
    run = 1;
    n = 0;
    while (state == 2'd0 && n < 6) begin cyc(); n++; end
    chk("resume_cnt", int'(dut.cnt), 3);

    run_until(3);
    run = 0;
    repeat (3) cyc();
    chk("drain_state", int'(state), M_DRAIN);
    ticks = 0; n = 0;
    while (n < 12) begin
      cyc(); n++;
      ticks += int'(tick);
      if (state == 2'd0) break;
    end
    chk("drain_ticks", ticks, 1);
    chk("drain_cnt", int'(dut.cnt), 0);
    chk("drain_plso", int'(plso), 0);

    step = 1;
    cyc();
    step = 0;
    ticks = 0; highs = 0;
    for (int i = 0; i < 20; i++) begin
      step = (i == 4) ? 1 : 0;
      cyc();
      ticks += int'(tick);
      highs += int'(plso);
    end
    chk("step_ticks", ticks, 1);
    chk("step_highs", highs, P / 2);
    chk("step_state", int'(state), M_IDLE);
    chk("step_cnt", int'(dut.cnt), 0);

    run = 1;
    run_until(7);
    run_until(6);
    clr = 1;
    cyc();
    chk("clr_pre", int'(dut.cnt), 7);
    cyc();
    clr = 0;
    chk("clr_cnt", int'(dut.cnt), 0);
    chk("clr_plso", int'(plso), 0);
    chk("clr_tick", int'(tick), 0);
    n = 0;
    while (n < 12) begin
      cyc(); n++;
      if (tick) break;
    end
    chk("clr_next_tick", n, P);

    run_until(6);
    #2 rst = 0;
    #1;
    chk("arst_plso", int'(plso), 0);
    chk("arst_tick", int'(tick), 0);
    chk("arst_cnt", int'(dut.cnt), 0);
    chk("arst_state", int'(state), M_IDLE);
    cyc();
    rst = 1;

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(23) == 0) run = ~run;
      step = ($urandom_range(11) == 0);
      clr = ($urandom_range(49) == 0);
      rst = ($urandom_range(399) != 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
